regfile_rdmux: RTL and testbench

REGFILE_RDMUX -- requirements
Module: regfile_rdmux

---
 rtl/regfile_rdmux.sv | 77 +++++++
 tb/tb_regfile_rdmux.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/regfile_rdmux.sv
// Register file with NRD independent registered read ports, write-to-read bypass,
// an optional hard-wired zero register and combinational output gating.
module regfile_rdmux #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD-1:0]       rd_req,
  input  logic [NRD*AW-1:0]    rd_addr,
  input  logic                 oe,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_commit;

  // Writes to the zero register are dropped before they reach the array.
  assign wr_commit = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    logic [AW-1:0]    addr;
    logic             is_zero;
    logic             bypass;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] held_word;
    logic             held_valid;

    assign addr    = rd_addr[p*AW +: AW];
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign bypass  = wr_en && (wr_addr == addr);

    // The zero register wins over bypass; otherwise same-cycle write data wins over the array.
    always_comb begin
      next_word = mem[addr];
      if (is_zero) begin
        next_word = '0;
      end else if (bypass) begin
        next_word = wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        held_word  <= '0;
        held_valid <= 1'b0;
      end else begin
        held_valid <= rd_req[p];
        if (rd_req[p]) begin
          held_word <= next_word;
        end
      end
    end

    // Gating sits after the holding registers so held data survives oe=0.
    assign rd_data[p*WIDTH +: WIDTH] = oe ? held_word : '0;
    assign rd_valid[p]               = oe & held_valid;
  end

endmodule

// File: tb/tb_regfile_rdmux.sv
// Directed self-checking bench for regfile_rdmux with hand-computed expectations.
module tb_regfile_rdmux;

  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                 clk;
  logic                 rst_n;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic [WIDTH-1:0]     wr_data;
  logic [NRD-1:0]       rd_req;
  logic [NRD*AW-1:0]    rd_addr;
  logic                 oe;
  logic [NRD*WIDTH-1:0] rd_data;
  logic [NRD-1:0]       rd_valid;

  int checks;
  int failures;

  regfile_rdmux #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH),
    .NRD(NRD),
    .ZERO_REG(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .oe(oe),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, then settle just after the next rising edge.
  task automatic applyStimulus(input logic we, input logic [AW-1:0] waddr,
                               input logic [31:0] wdata, input logic [1:0] req,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    wr_en   = we;
    wr_addr = waddr;
    wr_data = wdata;
    rd_req  = req;
    rd_addr = {a1, a0};
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_req   = '0;
    rd_addr  = '0;
    oe       = 1'b1;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;

    // Activity during reset must be ignored.
    applyStimulus(1'b1, 5'd9, 32'h9999_9999, 2'b11, 5'd9, 5'd9);
    applyStimulus(1'b1, 5'd9, 32'h9999_9999, 2'b11, 5'd9, 5'd9);
    checkOutput("reset_data", rd_data[31:0], 32'h0);
    checkOutput("reset_valid", {30'b0, rd_valid}, 32'h0);

    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'(i), 5'd0);
      checkOutput($sformatf("init_data_%0d", i), rd_data[31:0], 32'h0);
      checkOutput($sformatf("init_valid_%0d", i), {31'b0, rd_valid[0]}, 32'h1);
    end

    applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 2'b00, 5'd0, 5'd0);
    checkOutput("after_write_valid", {30'b0, rd_valid}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd5, 5'd5);
    checkOutput("rd5_p0", rd_data[31:0], 32'hDEAD_BEEF);
    checkOutput("rd5_p1", rd_data[63:32], 32'hDEAD_BEEF);
    checkOutput("rd5_valid", {30'b0, rd_valid}, 32'h3);

    // Bypass: port 0 sees new data, port 1 reads another address untouched.
    applyStimulus(1'b1, 5'd7, 32'h1234_5678, 2'b11, 5'd7, 5'd5);
    checkOutput("bypass_p0", rd_data[31:0], 32'h1234_5678);
    checkOutput("bypass_p1", rd_data[63:32], 32'hDEAD_BEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd7);
    checkOutput("stored7_p1", rd_data[63:32], 32'h1234_5678);
    checkOutput("hold_p0", rd_data[31:0], 32'h1234_5678);
    checkOutput("hold_valid", {30'b0, rd_valid}, 32'h2);

    applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 2'b01, 5'd0, 5'd0);
    checkOutput("zero_bypass", rd_data[31:0], 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b11, 5'd0, 5'd0);
    checkOutput("zero_read_p0", rd_data[31:0], 32'h0);
    checkOutput("zero_read_p1", rd_data[63:32], 32'h0);
    checkOutput("zero_read_valid", {30'b0, rd_valid}, 32'h3);

    applyStimulus(1'b1, 5'd10, 32'hA5A5_A5A5, 2'b00, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd10, 5'd0);
    checkOutput("hold_a5", rd_data[31:0], 32'hA5A5_A5A5);
    oe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
      checkOutput($sformatf("oe_off_data_%0d", i), rd_data[31:0], 32'h0);
      checkOutput($sformatf("oe_off_valid_%0d", i), {30'b0, rd_valid}, 32'h0);
    end
    oe = 1'b1;
    #1;
    checkOutput("oe_on_data", rd_data[31:0], 32'hA5A5_A5A5);
    checkOutput("oe_on_valid", {30'b0, rd_valid}, 32'h0);

    // A completed request stays hidden under oe=0 and reappears when enabled.
    oe = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd5);
    checkOutput("oe_off_req_valid", {30'b0, rd_valid}, 32'h0);
    oe = 1'b1;
    #1;
    checkOutput("oe_on_req_data", rd_data[63:32], 32'hDEAD_BEEF);
    checkOutput("oe_on_req_valid", {30'b0, rd_valid}, 32'h2);

    applyStimulus(1'b1, 5'd3, 32'h3333_3333, 2'b00, 5'd0, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0);
    checkOutput("rd3_before_reset", rd_data[31:0], 32'h3333_3333);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_data", rd_data[31:0], 32'h0);
    checkOutput("async_reset_valid", {30'b0, rd_valid}, 32'h0);
    #1 rst_n = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0);
    checkOutput("rd3_after_reset", rd_data[31:0], 32'h0);
    checkOutput("rd3_after_reset_valid", {31'b0, rd_valid[0]}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
